// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the pipeline stage registers.
//   skid_state_t : occupancy of a skid-buffered stage (EMPTY/HALF/FULL)
//   RV_NOP       : RISC-V canonical NOP (addi x0,x0,0), the bubble payload
//   if_id_t / id_ex_t : payload layouts carried by the IF/ID and ID/EX stages
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  localparam logic [31:0] RV_NOP = 32'h00000013;
  localparam int          XLEN   = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [31:0]     instr;
  } if_id_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [15:0]     ctrl;
  } id_ex_t;

  localparam int IF_ID_W = $bits(if_id_t);
  localparam int ID_EX_W = $bits(id_ex_t);

endpackage

// File: rtl/pipe_sat_ctr.sv
// pipe_sat_ctr: W-bit up counter with increment enable that sticks at
// all-ones. Cleared only by reset.
//   clk, reset_n : clock, async active-low reset
//   inc          : count this cycle
//   cnt          : current count
module pipe_sat_ctr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic pipeline stage register with valid/ready
// handshake, 2-entry skid (main + skid registers) and synchronous flush
// that reloads both registers with a NOP bubble.
//   clk, reset_n         : clock, async active-low reset
//   flush                : drop everything held, go EMPTY
//   in_valid/in_ready/in_data    : upstream handshake (in_ready is a flop decode)
//   out_valid/out_ready/out_data : downstream handshake, out_data = main register
//   stall_cnt, flush_cnt : saturating perf counters, present only when
//                          PIPE_STAGE_PERF_EN is defined
import pipe_pkg::*;

module pipe_stage_skid #(
  parameter int                DATA_W    = 96,
  parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(RV_NOP),
  parameter int                PERF_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef PIPE_STAGE_PERF_EN
  output logic [DATA_W-1:0] out_data,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`else
  output logic [DATA_W-1:0] out_data
`endif
);

  skid_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire, out_fire;

  // Handshake outputs decode state only: no ready/valid comb path across us.
  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_FULL);
  assign out_data  = main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_HALF;
            main_d  = in_data;
          end
        end
        ST_HALF: begin
          if (in_fire && !out_fire) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (in_fire && out_fire) begin
            main_d  = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            main_d  = NOP_VALUE;
          end
        end
        ST_FULL: begin
          // Older payload (main) leaves first; skid slides forward.
          if (out_fire) begin
            state_d = ST_HALF;
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_ctr #(.W(PERF_W)) u_stall_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (in_valid & ~in_ready),
    .cnt     (stall_cnt)
  );

  pipe_sat_ctr #(.W(PERF_W)) u_flush_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (flush),
    .cnt     (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid. Reference model is a bounded FIFO queue of
// depth 2: head is what the stage presents, an empty queue presents NOP.
// Build with +define+PIPE_STAGE_PERF_EN to include the perf-counter checks.
module tb_pipe_stage_skid;

  localparam int DW   = 96;
  localparam int PW   = 4;
  localparam int SMAX = 15;
  localparam logic [DW-1:0] NOP = {64'd0, 32'h00000013};

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [PW-1:0] stall_cnt, flush_cnt;
`endif

  pipe_stage_skid #(.DATA_W(DW), .PERF_W(PW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef PIPE_STAGE_PERF_EN
    .out_data  (out_data),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`else
    .out_data  (out_data)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mq[$];
  int m_stall, m_flush;
  int n_checks, n_fail;

  function automatic bit e_valid();
    return mq.size() != 0;
  endfunction
  function automatic bit e_ready();
    return mq.size() < 2;
  endfunction
  function automatic logic [DW-1:0] e_data();
    return (mq.size() != 0) ? mq[0] : NOP;
  endfunction

  // Drive one cycle, advance the model on the edge, land 1 time unit after it.
  task automatic tick(input bit iv, input logic [DW-1:0] d, input bit ordy, input bit fl);
    bit ifire, ofire;
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    @(posedge clk);
    ifire = iv && e_ready();
    ofire = ordy && e_valid();
    if (iv && !e_ready()) m_stall = (m_stall >= SMAX) ? SMAX : m_stall + 1;
    if (fl) begin
      m_flush = (m_flush >= SMAX) ? SMAX : m_flush + 1;
      mq.delete();
    end else begin
      if (ofire) void'(mq.pop_front());
      if (ifire) mq.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL reset_hs: got v=%0b r=%0b want v=0 r=1", out_valid, in_ready);
    end
    n_checks++;
    if (out_data !== NOP) begin
      n_fail++; $display("FAIL reset_data: got %h want %h", out_data, NOP);
    end
`ifdef PIPE_STAGE_PERF_EN
    n_checks++;
    if ({stall_cnt, flush_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
`endif
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_latency_stream();
    tick(1'b1, DW'('hA5), 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== DW'('hA5)) begin
      n_fail++; $display("FAIL first_lat: got v=%0b d=%h want v=1 d=a5", out_valid, out_data);
    end
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1, DW'(k), 1'b1, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== DW'(k) || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL stream_%0d: got v=%0b r=%0b d=%h want v=1 r=1 d=%0d", k, out_valid, in_ready, out_data, k);
      end
    end
    tick(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== NOP) begin
      n_fail++; $display("FAIL stream_drain: got v=%0b d=%h want v=0 d=%h", out_valid, out_data, NOP);
    end
  endtask

  task automatic test_backpressure();
    tick(1'b1, DW'('h11), 1'b0, 1'b0);
    tick(1'b1, DW'('h22), 1'b0, 1'b0);
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== DW'('h11)) begin
      n_fail++; $display("FAIL bp_full: got r=%0b v=%0b d=%h want r=0 v=1 d=11", in_ready, out_valid, out_data);
    end
    tick(1'b1, DW'('h99), 1'b0, 1'b0);
    n_checks++;
    if (out_data !== DW'('h11) || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_hold: got r=%0b d=%h want r=0 d=11", in_ready, out_data);
    end
    tick(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== DW'('h22) || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_second: got v=%0b r=%0b d=%h want v=1 r=1 d=22", out_valid, in_ready, out_data);
    end
    tick(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== NOP) begin
      n_fail++; $display("FAIL bp_empty: got v=%0b d=%h want v=0 d=%h", out_valid, out_data, NOP);
    end
  endtask

  task automatic test_flush_full();
    tick(1'b1, DW'('h31), 1'b0, 1'b0);
    tick(1'b1, DW'('h32), 1'b0, 1'b0);
    tick(1'b1, DW'('h33), 1'b1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== NOP) begin
      n_fail++; $display("FAIL flush_full: got v=%0b r=%0b d=%h want v=0 r=1 d=%h", out_valid, in_ready, out_data, NOP);
    end
    tick(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_noskid: got v=%0b want v=0", out_valid);
    end
  endtask

  task automatic test_half_passthru();
    tick(1'b1, DW'('h41), 1'b0, 1'b0);
    tick(1'b1, DW'('h42), 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== DW'('h42)) begin
      n_fail++; $display("FAIL half_swap: got v=%0b r=%0b d=%h want v=1 r=1 d=42", out_valid, in_ready, out_data);
    end
    tick(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL half_stayed: got v=%0b want v=0", out_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 3) != 0, {$urandom(), $urandom(), $urandom()},
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      n_checks++;
      if ({out_valid, in_ready, out_data} !== {e_valid(), e_ready(), e_data()}) begin
        n_fail++;
        $display("FAIL rand_%0d: got v=%0b r=%0b d=%h want v=%0b r=%0b d=%h",
                 i, out_valid, in_ready, out_data, e_valid(), e_ready(), e_data());
      end
`ifdef PIPE_STAGE_PERF_EN
      n_checks++;
      if (stall_cnt !== PW'(m_stall) || flush_cnt !== PW'(m_flush)) begin
        n_fail++; $display("FAIL rand_cnt_%0d: got %0d/%0d want %0d/%0d", i, stall_cnt, flush_cnt, m_stall, m_flush);
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    tick(1'b1, DW'('h51), 1'b0, 1'b0);
    tick(1'b1, DW'('h52), 1'b0, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    mq.delete(); m_stall = 0; m_flush = 0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== NOP) begin
      n_fail++; $display("FAIL async_rst: got v=%0b r=%0b d=%h want v=0 r=1 d=%h", out_valid, in_ready, out_data, NOP);
    end
`ifdef PIPE_STAGE_PERF_EN
    n_checks++;
    if ({stall_cnt, flush_cnt} !== '0) begin
      n_fail++; $display("FAIL async_rst_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
`endif
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_rst_lost: got v=%0b want v=0", out_valid);
    end
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    tick(1'b1, DW'('h61), 1'b0, 1'b0);
    tick(1'b1, DW'('h62), 1'b0, 1'b0);
    repeat (20) tick(1'b1, DW'('h63), 1'b0, 1'b0);
    n_checks++;
    if (stall_cnt !== PW'(15) || stall_cnt !== PW'(m_stall)) begin
      n_fail++; $display("FAIL stall_sat: got %0d want 15", stall_cnt);
    end
    repeat (3) tick(1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if (flush_cnt !== PW'(3) || stall_cnt !== PW'(15)) begin
      n_fail++; $display("FAIL flush_cnt: got f=%0d s=%0d want f=3 s=15", flush_cnt, stall_cnt);
    end
  endtask
`endif

  initial begin
    n_checks = 0; n_fail = 0; m_stall = 0; m_flush = 0;
    test_reset();
    test_latency_stream();
    test_backpressure();
    test_flush_full();
    test_half_passthru();
    test_random();
    test_async_reset();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
